fetch_sequencer: RTL and testbench

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/kgp_fetch_pkg.sv | 34 +++
 rtl/fetch_hold_buf.sv | 29 ++
 rtl/fetch_sequencer.sv | 147 ++++++++++++++
 tb/tb_fetch_sequencer.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/kgp_fetch_pkg.sv
// Shared types and defaults for the instruction fetch sequencer.
package kgp_fetch_pkg;

    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
    localparam int unsigned DEF_PC_STEP  = 4;

    // Sequencer states: request outstanding, instruction parked during stall,
    // in-flight request that must be thrown away after a redirect.
    typedef enum logic [1:0] {
        REQ  = 2'd0,
        HOLD = 2'd1,
        DROP = 2'd2
    } fetch_state_e;

    // What the IF/ID output registers do on the next edge.
    typedef enum logic [1:0] {
        OUT_KEEP   = 2'd0,
        OUT_BUBBLE = 2'd1,
        OUT_MEM    = 2'd2,
        OUT_BUF    = 2'd3
    } out_sel_e;

    // One fetched instruction together with the address it came from.
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_ent_t;

    // Sequential PC advance; wraps modulo 2^32 by construction.
    function automatic logic [31:0] pc_inc(input logic [31:0] pc, input logic [31:0] step);
        return pc + step;
    endfunction

endpackage

// File: rtl/fetch_hold_buf.sv
// Single-entry parking buffer for an instruction that arrived while the
// downstream IF/ID register was stalled.
module fetch_hold_buf
    import kgp_fetch_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic       clear,
    input  fetch_ent_t din,
    output logic       vld,
    output fetch_ent_t dout
);

    // Load wins over clear; both never coincide in the sequencer.
    always_ff @(posedge clk) begin
        if (!reset) begin
            vld  <= 1'b0;
            dout <= '0;
        end else if (load) begin
            vld  <= 1'b1;
            dout <= din;
        end else if (clear) begin
            vld  <= 1'b0;
            dout <= '0;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: issues sequential fetches, parks one
// instruction across downstream stalls and discards data on redirects.
module fetch_sequencer
    import kgp_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEF_RESET_PC,
    parameter int unsigned PC_STEP  = DEF_PC_STEP
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] fetch_count
);

    localparam logic [31:0] STEP = 32'(PC_STEP);

    fetch_state_e state, state_n;
    logic [31:0]  pc, pc_n;
    logic [31:0]  tgt, tgt_n;
    out_sel_e     out_sel;
    logic         buf_load, buf_clr, buf_vld;
    fetch_ent_t   buf_q;
    fetch_ent_t   buf_d;

    // The request is only dropped while parked in HOLD; reset kills it
    // combinationally so a late ack during reset is never consumed.
    assign imem_req  = reset && (state != HOLD);
    assign imem_addr = pc;
    assign buf_d     = '{instr: imem_rdata, pc: pc};

    fetch_hold_buf u_hold (
        .clk   (clk),
        .reset (reset),
        .load  (buf_load),
        .clear (buf_clr),
        .din   (buf_d),
        .vld   (buf_vld),
        .dout  (buf_q)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) state <= REQ;
        else        state <= state_n;
    end

    // Next-state, PC/target selection and output-register control.
    // Redirect is tested first everywhere so it beats stall.
    always_comb begin
        state_n  = state;
        pc_n     = pc;
        tgt_n    = tgt;
        out_sel  = OUT_KEEP;
        buf_load = 1'b0;
        buf_clr  = 1'b0;
        unique case (state)
            REQ: begin
                if (redirect) begin
                    out_sel = OUT_BUBBLE;
                    if (imem_ack) begin
                        pc_n = redirect_pc;
                    end else begin
                        // Data for the old pc is still coming; remember where to go.
                        tgt_n   = redirect_pc;
                        state_n = DROP;
                    end
                end else if (imem_ack) begin
                    pc_n = pc_inc(pc, STEP);
                    if (stall) begin
                        buf_load = 1'b1;
                        state_n  = HOLD;
                    end else begin
                        out_sel = OUT_MEM;
                    end
                end else if (!stall) begin
                    out_sel = OUT_BUBBLE;
                end
            end
            HOLD: begin
                if (redirect) begin
                    buf_clr = 1'b1;
                    pc_n    = redirect_pc;
                    out_sel = OUT_BUBBLE;
                    state_n = REQ;
                end else if (!stall) begin
                    buf_clr = 1'b1;
                    out_sel = buf_vld ? OUT_BUF : OUT_BUBBLE;
                    state_n = REQ;
                end
            end
            DROP: begin
                // Nothing deliverable while the stale response drains.
                out_sel = OUT_BUBBLE;
                if (redirect) tgt_n = redirect_pc;
                if (imem_ack) begin
                    pc_n    = redirect ? redirect_pc : tgt;
                    state_n = REQ;
                end
            end
            default: begin
                out_sel = OUT_BUBBLE;
                state_n = REQ;
            end
        endcase
    end

    // PC, redirect target and IF/ID output registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc          <= RESET_PC;
            tgt         <= '0;
            if_valid    <= 1'b0;
            if_instr    <= '0;
            if_pc       <= '0;
            fetch_count <= '0;
        end else begin
            pc  <= pc_n;
            tgt <= tgt_n;
            unique case (out_sel)
                OUT_BUBBLE: if_valid <= 1'b0;
                OUT_MEM: begin
                    if_valid    <= 1'b1;
                    if_instr    <= imem_rdata;
                    if_pc       <= pc;
                    fetch_count <= fetch_count + 32'd1;
                end
                OUT_BUF: begin
                    if_valid    <= 1'b1;
                    if_instr    <= buf_q.instr;
                    if_pc       <= buf_q.pc;
                    fetch_count <= fetch_count + 32'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: memory responders, delivery monitor,
// and directed scenarios for streaming, stall, redirect, drop, reset, wrap.
module tb_fetch_sequencer;
    import kgp_fetch_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, stall, redirect;
    logic [31:0] redirect_pc;
    logic        imem_req, imem_ack, if_valid;
    logic [31:0] imem_addr, imem_rdata, if_instr, if_pc, fetch_count;

    logic        reset_w, stall_w, redirect_w;
    logic [31:0] redirect_pc_w;
    logic        imem_req_w, imem_ack_w, if_valid_w;
    logic [31:0] imem_addr_w, imem_rdata_w, if_instr_w, if_pc_w, fetch_count_w;

    int n_chk = 0;
    int n_err = 0;
    int mem_lat = 1;
    int mem_left = 0;
    int mem_left_w = 0;
    fetch_ent_t exp_q[$];
    fetch_ent_t exp_q_w[$];

    fetch_sequencer dut (
        .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall),
        .redirect(redirect), .redirect_pc(redirect_pc), .if_valid(if_valid),
        .if_instr(if_instr), .if_pc(if_pc), .fetch_count(fetch_count)
    );

    fetch_sequencer #(.RESET_PC(32'hFFFF_FFFC), .PC_STEP(4)) dut_w (
        .clk(clk), .reset(reset_w), .imem_req(imem_req_w), .imem_addr(imem_addr_w),
        .imem_ack(imem_ack_w), .imem_rdata(imem_rdata_w), .stall(stall_w),
        .redirect(redirect_w), .redirect_pc(redirect_pc_w), .if_valid(if_valid_w),
        .if_instr(if_instr_w), .if_pc(if_pc_w), .fetch_count(fetch_count_w)
    );

    function automatic logic [31:0] mk_instr(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_A5A5;
    endfunction

    function automatic fetch_ent_t mk_ent(input logic [31:0] a);
        fetch_ent_t e;
        e.instr = mk_instr(a);
        e.pc    = a;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Main memory: ack after mem_lat cycles of a held request, mem_left acks
    // max; also checks the address never moves while a request waits.
    initial begin
        int wait_cnt;
        logic pend;
        logic [31:0] pend_addr;
        wait_cnt = 0; pend = 1'b0; pend_addr = '0;
        imem_ack = 1'b0; imem_rdata = '0;
        forever begin
            @(posedge clk);
            #2;
            if (pend && imem_req) chk("addr_stable", imem_addr, pend_addr);
            if (imem_req && mem_left > 0 && wait_cnt + 1 >= mem_lat) begin
                imem_ack   = 1'b1;
                imem_rdata = mk_instr(imem_addr);
                wait_cnt   = 0;
                mem_left--;
            end else begin
                imem_ack   = 1'b0;
                imem_rdata = '0;
                wait_cnt   = imem_req ? wait_cnt + 1 : 0;
            end
            pend      = imem_req && !imem_ack;
            pend_addr = imem_addr;
        end
    end

    // Zero-wait memory for the wrap instance.
    initial begin
        imem_ack_w = 1'b0; imem_rdata_w = '0;
        forever begin
            @(posedge clk);
            #2;
            if (imem_req_w && mem_left_w > 0) begin
                imem_ack_w   = 1'b1;
                imem_rdata_w = mk_instr(imem_addr_w);
                mem_left_w--;
            end else begin
                imem_ack_w   = 1'b0;
                imem_rdata_w = '0;
            end
        end
    end

    // Delivery monitor: an instruction is consumed when valid and not stalled.
    initial begin
        fetch_ent_t e;
        forever begin
            @(negedge clk);
            if (reset && if_valid && !stall) begin
                chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("sb_pc", if_pc, e.pc);
                    chk("sb_instr", if_instr, e.instr);
                end
            end
            if (reset_w && if_valid_w && !stall_w) begin
                chk("sbw_nonempty", 32'(exp_q_w.size() != 0), 32'd1);
                if (exp_q_w.size() != 0) begin
                    e = exp_q_w.pop_front();
                    chk("sbw_pc", if_pc_w, e.pc);
                    chk("sbw_instr", if_instr_w, e.instr);
                end
            end
        end
    end

    task automatic do_reset();
        reset = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        mem_left = 0; mem_lat = 1;
        repeat (2) tick();
        chk("rst_valid", 32'(if_valid), 32'd0);
        chk("rst_instr", if_instr, 32'd0);
        chk("rst_pc", if_pc, 32'd0);
        chk("rst_count", fetch_count, 32'd0);
        chk("rst_req", 32'(imem_req), 32'd0);
        exp_q.delete();
    endtask

    task automatic release_rst();
        reset = 1'b1;
        #1;
        chk("rel_req", 32'(imem_req), 32'd1);
        chk("rel_addr", imem_addr, 32'h0);
    endtask

    task automatic wait_addr(input string tag, input logic [31:0] a);
        int n;
        n = 0;
        while (imem_addr !== a && n < 50) begin
            tick();
            n++;
        end
        chk(tag, imem_addr, a);
    endtask

    task automatic drain(input string tag, input logic [31:0] cnt);
        chk({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
        chk({tag, "_count"}, fetch_count, cnt);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        reset_w = 1'b0; stall_w = 1'b0; redirect_w = 1'b0; redirect_pc_w = '0;

        // Zero-wait streaming: 0,4,8,12 on consecutive cycles.
        do_reset();
        mem_left = 4;
        for (int i = 0; i < 4; i++) exp_q.push_back(mk_ent(32'(4 * i)));
        release_rst();
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("a_valid", 32'(if_valid), 32'd1);
            chk("a_pc", if_pc, 32'(4 * i));
        end
        tick();
        chk("a_bubble", 32'(if_valid), 32'd0);
        drain("a", 32'd4);

        // Stall for three cycles while pc=8 is acked.
        do_reset();
        mem_left = 6;
        for (int i = 0; i < 6; i++) exp_q.push_back(mk_ent(32'(4 * i)));
        release_rst();
        wait_addr("b_addr8", 32'h8);
        stall = 1'b1;
        tick();
        chk("b_state", 32'(dut.state), 32'(HOLD));
        chk("b_req_off", 32'(imem_req), 32'd0);
        chk("b_frz_pc", if_pc, 32'h4);
        chk("b_frz_valid", 32'(if_valid), 32'd1);
        chk("b_frz_cnt", fetch_count, 32'd2);
        tick();
        chk("b_frz_pc2", if_pc, 32'h4);
        tick();
        chk("b_frz_pc3", if_pc, 32'h4);
        stall = 1'b0;
        tick();
        chk("b_buf_pc", if_pc, 32'h8);
        chk("b_buf_cnt", fetch_count, 32'd3);
        tick();
        chk("b_next_pc", if_pc, 32'hC);
        repeat (5) tick();
        drain("b", 32'd6);

        // Redirect coinciding with ack at 0x10.
        do_reset();
        mem_left = 7;
        exp_q.push_back(mk_ent(32'h0));
        exp_q.push_back(mk_ent(32'h4));
        exp_q.push_back(mk_ent(32'h8));
        exp_q.push_back(mk_ent(32'hC));
        exp_q.push_back(mk_ent(32'h100));
        exp_q.push_back(mk_ent(32'h104));
        release_rst();
        wait_addr("c_addr10", 32'h10);
        redirect = 1'b1; redirect_pc = 32'h100;
        tick();
        redirect = 1'b0;
        chk("c_bubble", 32'(if_valid), 32'd0);
        chk("c_addr", imem_addr, 32'h100);
        repeat (4) tick();
        drain("c", 32'd6);

        // Three-cycle memory, two redirects while the request waits.
        do_reset();
        mem_lat = 3; mem_left = 2;
        exp_q.push_back(mk_ent(32'h300));
        redirect = 1'b1; redirect_pc = 32'h200;
        release_rst();
        tick();
        chk("d_state", 32'(dut.state), 32'(DROP));
        chk("d_addr1", imem_addr, 32'h0);
        chk("d_valid", 32'(if_valid), 32'd0);
        redirect_pc = 32'h300;
        tick();
        redirect = 1'b0;
        chk("d_addr2", imem_addr, 32'h0);
        chk("d_req", 32'(imem_req), 32'd1);
        tick();
        chk("d_addr3", imem_addr, 32'h300);
        chk("d_valid2", 32'(if_valid), 32'd0);
        repeat (5) tick();
        drain("d", 32'd1);

        // Reset while parked in HOLD with stall held.
        do_reset();
        mem_left = 2;
        release_rst();
        tick();
        stall = 1'b1;
        tick();
        chk("e_state", 32'(dut.state), 32'(HOLD));
        chk("e_pc", if_pc, 32'h0);
        reset = 1'b0;
        tick();
        chk("e_valid", 32'(if_valid), 32'd0);
        chk("e_count", fetch_count, 32'd0);
        chk("e_req", 32'(imem_req), 32'd0);
        stall = 1'b0;
        release_rst();
        repeat (4) tick();
        drain("e", 32'd0);

        // PC wrap from 0xFFFFFFFC.
        mem_left_w = 2;
        exp_q_w.push_back(mk_ent(32'hFFFF_FFFC));
        exp_q_w.push_back(mk_ent(32'h0));
        reset_w = 1'b1;
        #1;
        chk("f_addr", imem_addr_w, 32'hFFFF_FFFC);
        tick();
        chk("f_pc0", if_pc_w, 32'hFFFF_FFFC);
        tick();
        chk("f_pc1", if_pc_w, 32'h0);
        repeat (3) tick();
        chk("f_drain", 32'(exp_q_w.size()), 32'd0);
        chk("f_count", fetch_count_w, 32'd2);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
